// File: rtl/dvi_fifo_writer_pkg.sv
// Pixel-path definitions shared by the FIFO writer and sync_controller:
// FIFO word layout, default active-area size and the writer state type.
package dvi_fifo_writer_pkg;

    localparam int WORD_W       = 44;
    localparam int X_HI         = 43;
    localparam int X_LO         = 34;
    localparam int Y_HI         = 33;
    localparam int Y_LO         = 24;
    localparam int R_HI         = 23;
    localparam int R_LO         = 16;
    localparam int G_HI         = 15;
    localparam int G_LO         = 8;
    localparam int B_HI         = 7;
    localparam int B_LO         = 0;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic {
        S_SYNC,
        S_RUN
    } wr_state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        logic [WORD_W-1:0] w;
        w             = '0;
        w[X_HI:X_LO]  = x;
        w[Y_HI:Y_LO]  = y;
        w[R_HI:R_LO]  = r;
        w[G_HI:G_LO]  = g;
        w[B_HI:B_LO]  = b;
        return w;
    endfunction

endpackage

// File: rtl/dvi_fifo_writer.sv
// Producer side of the DVI pixel FIFO: tracks active-area coordinates and
// writes one {x, y, r, g, b} word per in-range pixel, dropping on FIFO full.
module dvi_fifo_writer
    import dvi_fifo_writer_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter logic VS_POL   = 1'b1
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              de,
    input  logic              vsync,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              wrfull,
    output logic              wrclk,
    output logic              wrreq,
    output logic [WORD_W-1:0] data,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic              frame_err
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    wr_state_t         state, state_n;
    logic [9:0]        x, x_n, y, y_n;
    logic              de_d;
    logic              wrreq_n, overflow_n, frame_err_n;
    logic [WORD_W-1:0] data_n;
    logic [15:0]       drop_count_n;
    logic              vs_on, in_range;

    assign wrclk    = clk_25;
    assign vs_on    = (vsync == VS_POL);
    assign in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        wrreq_n      = 1'b0;
        data_n       = data;
        overflow_n   = overflow;
        drop_count_n = drop_count;
        frame_err_n  = frame_err;
        case (state)
            S_SYNC: begin
                if (vs_on) state_n = S_RUN;
            end
            S_RUN: begin
                // vsync takes priority over both pixels and the line-end edge
                if (vs_on) begin
                    x_n = '0;
                    y_n = '0;
                end else if (de) begin
                    if (x != 10'h3FF) x_n = x + 10'd1;
                    if (!in_range) begin
                        frame_err_n = 1'b1;
                    end else if (wrfull) begin
                        overflow_n = 1'b1;
                        if (drop_count != 16'hFFFF) drop_count_n = drop_count + 16'd1;
                    end else begin
                        wrreq_n = 1'b1;
                        data_n  = pack_word(x, y, pix_r, pix_g, pix_b);
                    end
                end else if (de_d) begin
                    x_n = '0;
                    if (y != 10'h3FF) y_n = y + 10'd1;
                end
            end
            default: state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_SYNC;
            x          <= '0;
            y          <= '0;
            de_d       <= 1'b0;
            wrreq      <= 1'b0;
            data       <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            de_d       <= de;
            wrreq      <= wrreq_n;
            data       <= data_n;
            overflow   <= overflow_n;
            drop_count <= drop_count_n;
            frame_err  <= frame_err_n;
        end
    end

endmodule
